// File: rtl/inc_seq_pkg.sv
// Shared types and constants for the nibble-serial increment sequencer.
// State encoding, nibble width and index-width helper.
package inc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  function automatic int nib_w(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/inc_seq_ctrl_increment.sv
// 4-bit increment cell: S = A + inc, Co = carry out of bit 3.
// Purely combinational datapath shared by the sequencer.
module increment (
  input  logic [3:0] A,
  input  logic       inc,
  output logic [3:0] S,
  output logic       Co
);

  assign {Co, S} = {1'b0, A} + {4'b0000, inc};

endmodule

// File: rtl/inc_seq_ctrl.sv
// Nibble-serial WIDTH-bit incrementer around one shared 4-bit cell.
// Define INC_SEQ_EARLY_EXIT_EN to finish as soon as the carry dies.
module inc_seq_ctrl
  import inc_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic             op_inc,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_co
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int NIB_W = nib_w(NIB);
  localparam logic [NIB_W-1:0] K_LAST = NIB_W'(NIB - 1);

  state_t state;
  state_t state_nx;

  logic [NIB_W-1:0]    k;
  logic                carry;
  logic [WIDTH-1:0]    work;
  logic [WIDTH-1:0]    work_nx;
  logic [NIBBLE_W-1:0] cell_a;
  logic [NIBBLE_W-1:0] cell_s;
  logic                cell_co;
  logic                accept;
  logic                last;
  logic                stop;

  assign start_ready = (state == IDLE);
  assign busy        = (state == RUN);
  assign res_valid   = (state == DONE);
  assign res_sum     = work;
  assign res_co      = carry;

  assign accept = start_valid & start_ready;
  assign last   = (k == K_LAST);

`ifdef INC_SEQ_EARLY_EXIT_EN
  // A dead carry leaves the upper nibbles already correct.
  assign stop = last | ~cell_co;
`else
  assign stop = last;
`endif

  always_comb begin
    cell_a = '0;
    for (int i = 0; i < NIB; i++) begin
      if (k == NIB_W'(i)) begin
        cell_a = work[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  increment u_inc (
    .A   (cell_a),
    .inc (carry),
    .S   (cell_s),
    .Co  (cell_co)
  );

  always_comb begin
    work_nx = work;
    for (int i = 0; i < NIB; i++) begin
      if (k == NIB_W'(i)) begin
        work_nx[i*NIBBLE_W +: NIBBLE_W] = cell_s;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept)    state_nx = RUN;
      RUN:  if (stop)      state_nx = DONE;
      DONE: if (res_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k     <= '0;
      carry <= 1'b0;
      work  <= '0;
    end else if (accept) begin
      k     <= '0;
      carry <= op_inc;
      work  <= op_a;
    end else if (state == RUN) begin
      k     <= k + 1'b1;
      carry <= cell_co;
      work  <= work_nx;
    end
  end

endmodule

// File: tb/tb_inc_seq_ctrl.sv
// Directed and random bench for inc_seq_ctrl at WIDTH=16.
// Expected latency follows INC_SEQ_EARLY_EXIT_EN when defined.
module tb_inc_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] op_a;
  logic        op_inc;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_sum;
  logic        res_co;

  int checks;
  int errors;

  inc_seq_ctrl #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_inc      (op_inc),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_sum     (res_sum),
    .res_co      (res_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] a, input logic inc);
`ifdef INC_SEQ_EARLY_EXIT_EN
    logic c;
    c = inc;
    for (int i = 0; i < 4; i++) begin
      c = c & (a[i*4 +: 4] == 4'hF);
      if (!c) return i + 1;
    end
    return 4;
`else
    return 4;
`endif
  endfunction

  task automatic accept(input logic [15:0] a, input logic inc);
    int n;
    n = 0;
    @(negedge clk);
    while (!start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", start_ready, 1);
    start_valid = 1'b1;
    op_a        = a;
    op_inc      = inc;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    op_a        = 16'h5A5A;
    op_inc      = 1'b1;
    chk("busy_run", busy, 1);
  endtask

  task automatic collect(input logic [15:0] a,
                         input logic inc,
                         input int stall);
    int lat;
    logic [16:0] ref_v;
    lat   = 0;
    ref_v = {1'b0, a} + {16'h0000, inc};
    while (!res_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, exp_lat(a, inc));
    chk("res_valid", res_valid, 1);
    chk("res_sum", res_sum, ref_v[15:0]);
    chk("res_co", res_co, ref_v[16]);
    chk("done_start_ready", start_ready, 0);
    chk("done_busy", busy, 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", res_valid, 1);
      chk("hold_sum", res_sum, ref_v[15:0]);
      chk("hold_co", res_co, ref_v[16]);
      chk("hold_start_ready", start_ready, 0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("release_valid", res_valid, 0);
    chk("release_start_ready", start_ready, 1);
  endtask

  initial begin
    logic [15:0] ra;
    logic        ri;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    op_a        = 16'h0;
    op_inc      = 1'b0;
    res_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_sum", res_sum, 16'h0000);
    chk("rst_res_co", res_co, 0);
    @(negedge clk);
    rst_n = 1'b1;

    accept(16'h00FF, 1'b1);
    collect(16'h00FF, 1'b1, 0);
    accept(16'hFFFF, 1'b1);
    collect(16'hFFFF, 1'b1, 0);
    accept(16'h1234, 1'b0);
    collect(16'h1234, 1'b0, 0);

    // backpressure with a second request parked on start_valid
    accept(16'h00FF, 1'b1);
    @(negedge clk);
    start_valid = 1'b1;
    op_a        = 16'hAAAA;
    op_inc      = 1'b1;
    collect(16'h00FF, 1'b1, 5);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    op_a        = 16'h5A5A;
    chk("second_accept_busy", busy, 1);
    collect(16'hAAAA, 1'b1, 0);

    // reset in the middle of RUN
    accept(16'hFFFF, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_run_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_start_ready", start_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_res_sum", res_sum, 16'h0000);
    chk("abort_res_co", res_co, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_valid", res_valid, 0);
    end
    accept(16'h0001, 1'b1);
    collect(16'h0001, 1'b1, 0);

    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      ri = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) ra[7:0] = 8'hFF;
      if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
      accept(ra, ri);
      collect(ra, ri, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
